// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encoding and default phase numbering for the phase sequencer.
package core_seq_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    WAIT_I = 3'd2,
    WAIT_D = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } seq_state_e;
  localparam int PH_IFU = 0;
  localparam int PH_DEC = 1;
  localparam int PH_EXU = 2;
  localparam int PH_MAU = 3;
  localparam int PH_WBU = 4;
endpackage

// File: rtl/core_phase_seq_if.sv
// core_phase_seq_if: control inputs and phase/status outputs between the core and its sequencer.
interface core_phase_seq_if #(
  parameter int CNT_W    = 4,
  parameter int RETIRE_W = 32
);
  logic                run_en;
  logic                itcm_hready;
  logic                dtcm_hready;
  logic                mem_req;
  logic                halt_req;
  logic [CNT_W-1:0]    cycle_cnt;
  logic                ifu_dec_stall;
  logic                retire_pulse;
  logic [RETIRE_W-1:0] retire_cnt;
  logic                bus_err;
  logic [CNT_W-1:0]    err_phase;
  logic [2:0]          seq_state;
  modport master (
    output run_en, itcm_hready, dtcm_hready, mem_req, halt_req,
    input  cycle_cnt, ifu_dec_stall, retire_pulse, retire_cnt, bus_err, err_phase, seq_state
  );
  modport slave (
    input  run_en, itcm_hready, dtcm_hready, mem_req, halt_req,
    output cycle_cnt, ifu_dec_stall, retire_pulse, retire_cnt, bus_err, err_phase, seq_state
  );
endinterface

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: saturating wait-cycle counter; expired flags the cycle whose count would reach TIMEOUT.
module seq_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expired = en && cnt >= W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/core_phase_seq.sv
// core_phase_seq: multicycle phase sequencer with bus wait states, timeout error, halt/drain and retire count.
module core_phase_seq
  import core_seq_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int NUM_PHASES  = PH_WBU + 1,
  parameter int FETCH_PHASE = PH_IFU,
  parameter int MEM_PHASE   = PH_MAU,
  parameter int TIMEOUT     = 16,
  parameter int RETIRE_W    = 32
) (
  input logic hclk,
  input logic hrst,
  core_phase_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] FP   = CNT_W'(FETCH_PHASE);
  localparam logic [CNT_W-1:0] MP   = CNT_W'(MEM_PHASE);
  seq_state_e          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc, err_ph;
  logic [RETIRE_W-1:0] ret;
  logic                pulse, pulse_n, err;
  logic                last, waiting, rdy, stall_i, stall_d, adv, expired;
  assign last    = cnt == LAST;
  assign cnt_inc = last ? '0 : cnt + 1'b1;
  assign waiting = state == WAIT_I || state == WAIT_D;
  assign rdy     = state == WAIT_I ? bus.itcm_hready : bus.dtcm_hready;
  assign stall_i = state == RUN && cnt == FP && !bus.itcm_hready;
  assign stall_d = state == RUN && cnt == MP && bus.mem_req && !bus.dtcm_hready;
  // a phase advances either from an unblocked RUN cycle or from the ready that ends a wait
  assign adv     = (state == RUN && !stall_i && !stall_d) || (waiting && rdy);
  seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (hclk),
    .rst     (hrst),
    .clr     (!waiting),
    .en      (waiting),
    .expired (expired)
  );
  always_comb begin
    cnt_n   = adv ? cnt_inc : cnt;
    pulse_n = adv && last;
    state_n = state;
    if (adv) state_n = !last ? RUN : bus.halt_req ? HALT : bus.run_en ? RUN : IDLE;
    else if (stall_i) state_n = WAIT_I;
    else if (stall_d) state_n = WAIT_D;
    else if (waiting && expired) state_n = ERR;
    else if (state == IDLE && bus.run_en) state_n = RUN;
  end
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state  <= IDLE;
      cnt    <= '0;
      pulse  <= 1'b0;
      ret    <= '0;
      err    <= 1'b0;
      err_ph <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pulse <= pulse_n;
      ret   <= ret + RETIRE_W'(pulse_n);
      if (state_n == ERR && state != ERR) begin
        err    <= 1'b1;
        err_ph <= cnt;
      end
    end
  end
  assign bus.cycle_cnt     = cnt;
  assign bus.ifu_dec_stall = state != RUN;
  assign bus.retire_pulse  = pulse;
  assign bus.retire_cnt    = ret;
  assign bus.bus_err       = err;
  assign bus.err_phase     = err_ph;
  assign bus.seq_state     = state;
endmodule

// File: tb/tb_core_phase_seq.sv
// tb_core_phase_seq: directed vector table plus hand sequences for timeout and ready-at-timeout.
module tb_core_phase_seq;
  localparam int TIMEOUT = 16;
  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  cnt;
    logic        stall;
    logic        pulse;
    logic [31:0] ret;
    logic        err;
    logic [3:0]  eph;
  } obs_t;
  typedef struct {
    logic r, run, ih, dh, mr, hr;
    obs_t exp;
  } vec_t;
  logic hclk = 1'b0;
  logic hrst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vq[$];
  always #5 hclk = ~hclk;
  core_phase_seq_if #(.CNT_W(4), .RETIRE_W(32)) bus ();
  core_phase_seq #(.TIMEOUT(TIMEOUT)) dut (.hclk(hclk), .hrst(hrst), .bus(bus));
  function automatic obs_t o(int st, int cnt, int stall, int pulse, int ret, int err, int eph);
    o = '{st: 3'(st), cnt: 4'(cnt), stall: 1'(stall), pulse: 1'(pulse), ret: 32'(ret), err: 1'(err), eph: 4'(eph)};
  endfunction
  function automatic void v(bit r, bit run, bit ih, bit dh, bit mr, bit hr, obs_t e);
    vec_t x;
    x.r = r; x.run = run; x.ih = ih; x.dh = dh; x.mr = mr; x.hr = hr; x.exp = e;
    vq.push_back(x);
  endfunction
  task automatic step(bit r, bit run, bit ih, bit dh, bit mr, bit hr);
    hrst = r; bus.run_en = run; bus.itcm_hready = ih; bus.dtcm_hready = dh; bus.mem_req = mr; bus.halt_req = hr;
    @(posedge hclk);
    #1;
  endtask
  task automatic chk(string name, obs_t e);
    obs_t a;
    a = '{st: bus.seq_state, cnt: bus.cycle_cnt, stall: bus.ifu_dec_stall, pulse: bus.retire_pulse,
          ret: bus.retire_cnt, err: bus.bus_err, eph: bus.err_phase};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got st=%0d cnt=%0d stall=%0b pulse=%0b ret=%0d err=%0b eph=%0d, want st=%0d cnt=%0d stall=%0b pulse=%0b ret=%0d err=%0b eph=%0d",
               name, a.st, a.cnt, a.stall, a.pulse, a.ret, a.err, a.eph, e.st, e.cnt, e.stall, e.pulse, e.ret, e.err, e.eph);
    end
  endtask
  task automatic to_wait_d();
    step(1, 0, 1, 1, 0, 0); chk("rst", o(0, 0, 1, 0, 0, 0, 0));
    step(0, 1, 1, 1, 0, 0); chk("start", o(1, 0, 0, 0, 0, 0, 0));
    for (int p = 1; p <= 3; p++) begin
      step(0, 1, 1, 1, 1, 0); chk("adv", o(1, p, 0, 0, 0, 0, 0));
    end
    step(0, 1, 1, 0, 1, 0); chk("enter_wd", o(3, 3, 1, 0, 0, 0, 0));
  endtask
  initial begin
    // test 1: three clean instructions, second with off-phase bus noise
    v(1,0,1,1,0,0, o(0,0,1,0,0,0,0));
    v(0,1,1,1,0,0, o(1,0,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,1,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,2,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,3,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,4,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,0,0,1,1,0,0));
    v(0,1,1,0,1,0, o(1,1,0,0,1,0,0));
    v(0,1,0,0,1,0, o(1,2,0,0,1,0,0));
    v(0,1,0,0,1,0, o(1,3,0,0,1,0,0));
    v(0,1,0,1,1,0, o(1,4,0,0,1,0,0));
    v(0,1,0,0,1,0, o(1,0,0,1,2,0,0));
    v(0,1,1,1,0,0, o(1,1,0,0,2,0,0));
    v(0,1,1,1,0,0, o(1,2,0,0,2,0,0));
    v(0,1,1,1,1,0, o(1,3,0,0,2,0,0));
    v(0,1,1,1,1,0, o(1,4,0,0,2,0,0));
    v(0,1,1,1,0,0, o(1,0,0,1,3,0,0));
    // test 2: three fetch wait cycles
    v(0,1,0,1,0,0, o(2,0,1,0,3,0,0));
    v(0,1,0,1,0,0, o(2,0,1,0,3,0,0));
    v(0,1,0,1,0,0, o(2,0,1,0,3,0,0));
    v(0,1,1,1,0,0, o(1,1,0,0,3,0,0));
    v(0,1,1,1,0,0, o(1,2,0,0,3,0,0));
    v(0,1,1,1,0,0, o(1,3,0,0,3,0,0));
    v(0,1,1,1,0,0, o(1,4,0,0,3,0,0));
    v(0,1,1,1,0,0, o(1,0,0,1,4,0,0));
    // test 5: run_en dropped in phase 2 drains the instruction
    v(0,1,1,1,0,0, o(1,1,0,0,4,0,0));
    v(0,1,1,1,0,0, o(1,2,0,0,4,0,0));
    v(0,0,1,1,0,0, o(1,3,0,0,4,0,0));
    v(0,0,1,1,0,0, o(1,4,0,0,4,0,0));
    v(0,0,1,1,0,0, o(0,0,1,1,5,0,0));
    v(0,0,1,1,0,0, o(0,0,1,0,5,0,0));
    // test 6: reset while in WAIT_D, mem_req dropped mid-wait is ignored
    v(0,1,1,1,0,0, o(1,0,0,0,5,0,0));
    v(0,1,1,1,1,0, o(1,1,0,0,5,0,0));
    v(0,1,1,1,1,0, o(1,2,0,0,5,0,0));
    v(0,1,1,1,1,0, o(1,3,0,0,5,0,0));
    v(0,1,1,0,1,0, o(3,3,1,0,5,0,0));
    v(0,1,1,0,0,0, o(3,3,1,0,5,0,0));
    v(1,1,1,0,1,0, o(0,0,1,0,0,0,0));
    // test 4: halt_req off the last phase ignored; halt with run_en=0 in last phase
    v(0,1,1,1,0,0, o(1,0,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,1,0,0,0,0,0));
    v(0,1,1,1,0,1, o(1,2,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,3,0,0,0,0,0));
    v(0,1,1,1,0,0, o(1,4,0,0,0,0,0));
    v(0,0,1,1,0,1, o(4,0,1,1,1,0,0));
    v(0,1,1,1,0,0, o(4,0,1,0,1,0,0));
    v(0,1,1,1,0,0, o(4,0,1,0,1,0,0));
    v(1,1,1,1,0,0, o(0,0,1,0,0,0,0));
    foreach (vq[i]) begin
      step(vq[i].r, vq[i].run, vq[i].ih, vq[i].dh, vq[i].mr, vq[i].hr);
      chk($sformatf("vec%0d", i), vq[i].exp);
    end
    // test 3: data bus never ready -> ERR after TIMEOUT wait cycles, sticky until reset
    to_wait_d();
    for (int k = 1; k < TIMEOUT; k++) begin
      step(0, 1, 1, 0, 1, 0); chk($sformatf("wd_hold%0d", k), o(3, 3, 1, 0, 0, 0, 0));
    end
    step(0, 1, 1, 0, 1, 0); chk("timeout_err", o(5, 3, 1, 0, 0, 1, 3));
    step(0, 1, 1, 1, 0, 0); chk("err_sticky", o(5, 3, 1, 0, 0, 1, 3));
    step(1, 0, 1, 1, 0, 0); chk("err_rst", o(0, 0, 1, 0, 0, 0, 0));
    // ready in the same cycle the counter reaches TIMEOUT wins
    to_wait_d();
    for (int k = 1; k < TIMEOUT; k++) step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0); chk("ready_wins", o(1, 4, 0, 0, 0, 0, 0));
    step(0, 1, 1, 1, 0, 0); chk("ready_wins_retire", o(1, 0, 0, 1, 1, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_phase_seq.md
Name: core_phase_seq

Overview:
- Parametrised multicycle phase sequencer for the single-issue RV32I core.
- Generates the cycle_cnt phase index and the ifu_dec_stall signal that the IFU/DEC/EXU/MAU/WBU stages currently take as external inputs.
- Generalised beyond a fixed free-running count: configurable phase count, ITCM/DTCM wait-state insertion, bus-timeout error, halt/drain control and a retired-instruction counter.
- Sits inside the core top, beside the pipeline stages; owns all phase sequencing.

Parameters:
CNT_W, 4, width of cycle_cnt; NUM_PHASES must be <= 2**CNT_W
NUM_PHASES, 5, phases per instruction (IFU, DEC, EXU, MAU, WBU); legal range 2..2**CNT_W
FETCH_PHASE, 0, phase in which itcm_hready is checked; must be < NUM_PHASES
MEM_PHASE, 3, phase in which dtcm_hready is checked when mem_req=1; must be < NUM_PHASES and != FETCH_PHASE
TIMEOUT, 16, maximum consecutive wait cycles before bus error; must be >= 1
RETIRE_W, 32, width of retire_cnt

Ports:
hclk  in  1  core clock; all state updates on its rising edge
hrst  in  1  synchronous active-high reset
run_en  in  1  level; 1 = execute instructions, 0 = drain and idle
itcm_hready  in  1  instruction bus ready
dtcm_hready  in  1  data bus ready
mem_req  in  1  EXU load/store enable for the current instruction (exu_load_en | exu_store_en)
halt_req  in  1  halt request (ebreak/ecall decode); sampled only in the last phase
cycle_cnt  out  CNT_W  current phase index
ifu_dec_stall  out  1  1 = stages must hold; asserted in every non-RUN state
retire_pulse  out  1  one-cycle pulse when an instruction completes
retire_cnt  out  RETIRE_W  count of retired instructions; wraps modulo 2**RETIRE_W
bus_err  out  1  sticky timeout error flag
err_phase  out  CNT_W  cycle_cnt value at the time of the error
seq_state  out  3  encoded FSM state, for debug

Behaviour:
- Reset (hrst=1 at an edge) forces the following, regardless of the current state:
  - seq_state=IDLE, cycle_cnt=0, ifu_dec_stall=1
  - retire_pulse=0, retire_cnt=0, bus_err=0, err_phase=0
  - wait counter=0
- States: IDLE, RUN, WAIT_I, WAIT_D, HALT, ERR.
- IDLE: cycle_cnt holds 0, stall=1. run_en=1 -> RUN on the next edge; first RUN cycle has cycle_cnt=0.
- RUN: stall=0. Each cycle, evaluate in this priority order:
  - cycle_cnt==FETCH_PHASE and itcm_hready=0 -> WAIT_I. cycle_cnt holds; stall=1 from the next cycle.
  - cycle_cnt==MEM_PHASE and mem_req=1 and dtcm_hready=0 -> WAIT_D. cycle_cnt holds.
  - cycle_cnt==NUM_PHASES-1 (last phase):
    - retire_pulse=1 the following cycle; retire_cnt increments by 1 in the same cycle.
    - cycle_cnt wraps to 0.
    - Next state, in priority order: halt_req=1 -> HALT; else run_en=0 -> IDLE; else stay in RUN.
  - Otherwise cycle_cnt increments by 1.
- run_en=0 mid-instruction has no effect until the last phase; an instruction always completes.
- WAIT_I / WAIT_D:
  - stall=1; cycle_cnt frozen at FETCH_PHASE / MEM_PHASE.
  - Wait counter increments each cycle. The ready input is sampled each cycle:
    - itcm_hready=1 (WAIT_I) or dtcm_hready=1 (WAIT_D) -> RUN; cycle_cnt advances by 1 on that same edge; wait counter cleared.
    - Wait counter reaches TIMEOUT with ready still 0 -> ERR.
  - Ready asserted in the same cycle the counter reaches TIMEOUT: ready wins (go to RUN).
  - mem_req is sampled only on entry to WAIT_D; later changes are ignored.
- ERR:
  - bus_err=1 and err_phase=frozen cycle_cnt, both set on entry.
  - stall=1; cycle_cnt held. Exit only via hrst.
- HALT: stall=1, cycle_cnt=0; run_en is ignored. Exit only via hrst.
- retire_pulse is registered, exactly 1 cycle wide, and never asserted in IDLE, WAIT, HALT or ERR.
- Phase arithmetic is unsigned CNT_W-bit; no value >= NUM_PHASES is ever output.
- retire_cnt wraps from 2**RETIRE_W-1 to 0 without any flag.

Decomposition:
- Shared package core_seq_pkg holds:
  - the seq_state enum (IDLE=0, RUN=1, WAIT_I=2, WAIT_D=3, HALT=4, ERR=5)
  - default phase constants (PH_IFU=0, PH_DEC=1, PH_EXU=2, PH_MAU=3, PH_WBU=4)
- One sub-module, seq_wait_timer:
  - saturating counter with clear, enable and parameter TIMEOUT
  - outputs an expired flag
  - used for both wait states.

Test Plan:
1. Reset then run_en=1, both hready=1, mem_req=0, 3 instructions (15 cycles):
   - cycle_cnt sequence 0,1,2,3,4 repeated
   - retire_pulse on every 5th cycle; retire_cnt=3
   - stall=0 throughout RUN.
2. itcm_hready=0 for 3 cycles at phase 0:
   - WAIT_I for 3 cycles, cycle_cnt held at 0, stall=1
   - resumes at cycle_cnt=1; instruction retires 3 cycles later than nominal.
3. mem_req=1 and dtcm_hready=0 for 16 cycles at phase 3 (TIMEOUT=16):
   - ERR entered; bus_err=1, err_phase=3
   - stays in ERR until hrst=1, which clears all outputs.
4. halt_req=1 and run_en=0 together in phase 4:
   - retire_pulse=1, then HALT (seq_state=4); stall=1, cycle_cnt=0
   - run_en=1 afterwards has no effect.
5. run_en dropped in phase 2:
   - phases 3 and 4 still execute; retire occurs; then IDLE with cycle_cnt=0.
6. hrst=1 asserted in WAIT_D:
   - next cycle: IDLE, cycle_cnt=0, retire_cnt=0, bus_err=0, stall=1.
